// File: rtl/piso_shift_register_if.sv
// Handshake and serial-line bundle for piso_shift_register.
// The master side is the word source / serial consumer; the slave side is the shift register.
interface piso_shift_register_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             shift_en;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;
    logic             busy;

    modport master (
        output load_valid,
        output load_data,
        output shift_en,
        input  load_ready,
        input  ser_out,
        input  ser_valid,
        input  ser_last,
        input  busy
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  shift_en,
        output load_ready,
        output ser_out,
        output ser_valid,
        output ser_last,
        output busy
    );
endinterface

// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out shift register with valid/ready load and per-cycle shift enable.
// Back-to-back words are accepted on the final bit so the serial stream has no gap.
module piso_shift_register #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    piso_shift_register_if.slave   bus
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CntW-1:0]  r_count;
    logic [CntW-1:0]  w_count_nxt;

    logic             w_shifting;
    logic             w_at_last;
    logic             w_final;
    logic             w_load_ready;
    logic             w_accept;
    logic             w_head;
    logic [WIDTH-1:0] w_shifted;

    assign w_shifting   = (r_state == StShift);
    assign w_at_last    = w_shifting && (r_count == LastIdx);
    assign w_final      = w_at_last && bus.shift_en;
    assign w_load_ready = (r_state == StIdle) || w_final;
    assign w_accept     = bus.load_valid && w_load_ready;

    // Head bit and shift direction both follow MSB_FIRST; vacated bits fill with 0.
    assign w_head    = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
    assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_count_nxt = r_count;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_nxt = StShift;
                    w_shreg_nxt = bus.load_data;
                    w_count_nxt = '0;
                end
            end
            StShift: begin
                if (bus.shift_en) begin
                    if (r_count == LastIdx) begin
                        if (w_accept) begin
                            w_shreg_nxt = bus.load_data;
                            w_count_nxt = '0;
                        end else begin
                            // count parks at the last index until the next load
                            w_state_nxt = StIdle;
                        end
                    end else begin
                        w_shreg_nxt = w_shifted;
                        w_count_nxt = r_count + CntW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_shreg <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign bus.ser_out    = w_shifting ? w_head : IDLE_LEVEL;
    assign bus.ser_valid  = w_shifting;
    assign bus.busy       = w_shifting;
    assign bus.ser_last   = w_at_last;
    assign bus.load_ready = w_load_ready;

endmodule

// File: tb/tb_piso_shift_register.sv
// Bench for piso_shift_register: an 8-bit MSB-first instance and a 4-bit LSB-first instance
// checked every cycle against a queue-of-pending-bits reference model.
module tb_piso_shift_register;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    piso_shift_register_if #(.WIDTH(8)) bus8 ();
    piso_shift_register_if #(.WIDTH(4)) bus4 ();

    piso_shift_register #(
        .WIDTH     (8),
        .MSB_FIRST (1'b1),
        .IDLE_LEVEL(1'b0)
    ) u_dut8 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus8)
    );

    piso_shift_register #(
        .WIDTH     (4),
        .MSB_FIRST (1'b0),
        .IDLE_LEVEL(1'b1)
    ) u_dut4 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus4)
    );

    // Bits still to be sent for the word in flight, head first.
    bit q8[$];
    bit q4[$];

    task automatic check(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " d8 ser_valid"}, bus8.ser_valid, 1'b0);
        check({tag, " d8 ser_out"}, bus8.ser_out, 1'b0);
        check({tag, " d8 ser_last"}, bus8.ser_last, 1'b0);
        check({tag, " d8 busy"}, bus8.busy, 1'b0);
        check({tag, " d8 load_ready"}, bus8.load_ready, 1'b1);
        check({tag, " d4 ser_valid"}, bus4.ser_valid, 1'b0);
        check({tag, " d4 ser_out"}, bus4.ser_out, 1'b1);
        check({tag, " d4 load_ready"}, bus4.load_ready, 1'b1);
    endtask

    task automatic drive_quiet();
        bus8.load_valid = 1'b0; bus8.load_data = '0; bus8.shift_en = 1'b0;
        bus4.load_valid = 1'b0; bus4.load_data = '0; bus4.shift_en = 1'b0;
    endtask

    // One clock on instance sel (0: 8-bit, 1: 4-bit): drive, check pre-edge outputs, advance model.
    task automatic step(input int sel, input logic lv, input logic [7:0] d, input logic se,
                        output logic acc);
        int   n;
        int   w;
        bit   msb;
        logic idle;
        logic head;
        logic e_ready;
        logic so, sv, sl, sb, sr;
        string t;
        w    = (sel == 0) ? 8 : 4;
        msb  = (sel == 0);
        idle = (sel == 0) ? 1'b0 : 1'b1;
        @(negedge clk);
        if (sel == 0) begin
            bus8.load_valid = lv; bus8.load_data = d; bus8.shift_en = se;
        end else begin
            bus4.load_valid = lv; bus4.load_data = d[3:0]; bus4.shift_en = se;
        end
        #1;
        if (sel == 0) begin
            so = bus8.ser_out; sv = bus8.ser_valid; sl = bus8.ser_last;
            sb = bus8.busy; sr = bus8.load_ready;
            n = q8.size(); head = (n > 0) ? q8[0] : 1'b0;
        end else begin
            so = bus4.ser_out; sv = bus4.ser_valid; sl = bus4.ser_last;
            sb = bus4.busy; sr = bus4.load_ready;
            n = q4.size(); head = (n > 0) ? q4[0] : 1'b0;
        end
        e_ready = (n == 0) || ((n == 1) && se);
        t = $sformatf("d%0d t=%0t", w, $time);
        check({t, " ser_valid"}, sv, n > 0);
        check({t, " busy"}, sb, n > 0);
        check({t, " ser_out"}, so, (n > 0) ? head : idle);
        check({t, " ser_last"}, sl, n == 1);
        check({t, " load_ready"}, sr, e_ready);
        acc = lv && e_ready;
        if (se && n > 0) begin
            if (sel == 0) void'(q8.pop_front()); else void'(q4.pop_front());
        end
        if (acc) begin
            for (int i = 0; i < w; i++) begin
                if (sel == 0) q8.push_back(msb ? d[w-1-i] : d[i]);
                else          q4.push_back(msb ? d[w-1-i] : d[i]);
            end
        end
    endtask

    task automatic random_run(input int sel, input int cycles);
        logic       lv;
        logic [7:0] d;
        logic       se;
        logic       acc;
        logic       pend;
        pend = 1'b0;
        lv   = 1'b0;
        d    = '0;
        for (int c = 0; c < cycles; c++) begin
            // An offered but unaccepted word must be held unchanged.
            if (!pend) begin
                lv = ($urandom_range(0, 2) != 0);
                d  = 8'($urandom);
            end
            se = ($urandom_range(0, 3) != 0);
            step(sel, lv, d, se, acc);
            pend = lv && !acc;
        end
        for (int c = 0; c < 12; c++) step(sel, 1'b0, 8'h00, 1'b1, acc);
    endtask

    initial begin
        logic acc;
        // Reset held with load_valid asserted: idle outputs and no capture.
        drive_quiet();
        bus8.load_valid = 1'b1; bus8.load_data = 8'hA5; bus8.shift_en = 1'b1;
        bus4.load_valid = 1'b1; bus4.load_data = 4'h3;  bus4.shift_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        drive_quiet();
        rst_n = 1'b1;
        step(0, 1'b0, 8'h00, 1'b1, acc);
        step(1, 1'b0, 8'h00, 1'b1, acc);

        // Single word 8'hA5, MSB first.
        step(0, 1'b1, 8'hA5, 1'b1, acc);
        for (int i = 0; i < 9; i++) step(0, 1'b0, 8'h00, 1'b1, acc);

        // Back-to-back: 8'h3C offered during the last bit of 8'hA5.
        step(0, 1'b1, 8'hA5, 1'b1, acc);
        for (int i = 0; i < 7; i++) step(0, 1'b0, 8'h00, 1'b1, acc);
        step(0, 1'b1, 8'h3C, 1'b1, acc);
        check("b2b accept", acc, 1'b1);
        for (int i = 0; i < 9; i++) step(0, 1'b0, 8'h00, 1'b1, acc);

        // Stall three cycles on bit 3.
        step(0, 1'b1, 8'hA5, 1'b1, acc);
        for (int i = 0; i < 3; i++) step(0, 1'b0, 8'h00, 1'b1, acc);
        for (int i = 0; i < 3; i++) step(0, 1'b0, 8'h00, 1'b0, acc);
        for (int i = 0; i < 6; i++) step(0, 1'b0, 8'h00, 1'b1, acc);

        // LSB first, 4-bit: load_valid held during bits 1-3 is refused.
        step(1, 1'b1, 8'h03, 1'b1, acc);
        for (int i = 0; i < 3; i++) begin
            step(1, 1'b1, 8'h0A, 1'b1, acc);
            check("d4 refused while busy", acc, 1'b0);
        end
        for (int i = 0; i < 6; i++) step(1, 1'b0, 8'h00, 1'b1, acc);

        // Reset mid-word at bit 5, asynchronous (between clock edges).
        step(0, 1'b1, 8'hA5, 1'b1, acc);
        for (int i = 0; i < 5; i++) step(0, 1'b0, 8'h00, 1'b1, acc);
        #2;
        rst_n = 1'b0;
        drive_quiet();
        #1;
        check_idle("async reset");
        q8.delete();
        q4.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1'b1, 8'hFF, 1'b1, acc);
        for (int i = 0; i < 9; i++) step(0, 1'b0, 8'h00, 1'b1, acc);

        // Randomized traffic on both widths.
        random_run(0, 400);
        random_run(1, 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
